// File: rtl/uart_tx_simple.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// One byte per valid/ready handshake; all bit timing comes from a clk-based period counter.
module uart_tx_simple #(
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY      = 0,
    parameter int STOP        = 1,
    parameter int CLK_FREQ_HZ = 33330000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_tx,
    output logic       tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_reg, parity_next;
    logic             tx_reg, tx_next;
    logic             ready_reg, ready_next;
    logic             done_reg, done_next;
    logic             bit_end;

    assign bit_end   = (clk_cnt_reg == CNT_LAST);
    assign tx_ready  = ready_reg;
    assign serial_tx = tx_reg;
    assign tx_done   = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            tx_reg      <= tx_next;
            ready_reg   <= ready_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        tx_next      = tx_reg;
        ready_next   = ready_reg;
        done_next    = 1'b0;

        if (state_reg != IDLE) begin
            clk_cnt_next = bit_end ? '0 : clk_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
                if (tx_valid && ready_reg) begin
                    shift_next   = tx_byte;
                    parity_next  = (PARITY == 1) ? ~^tx_byte : ^tx_byte;
                    ready_next   = 1'b0;
                    tx_next      = 1'b0;
                    clk_cnt_next = '0;
                    state_next   = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_next   = DATA_BITS;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            state_next = PARITY_BIT;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = STOP_BIT;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // Next bit is already at position 1 before the shift lands.
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end
            end
            PARITY_BIT: begin
                if (bit_end) begin
                    state_next   = STOP_BIT;
                    bit_cnt_next = '0;
                    tx_next      = 1'b1;
                end
            end
            STOP_BIT: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        ready_next   = 1'b1;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_simple.sv
// Bench for uart_tx_simple: three instances (8N1, 8O1, 8E2) with a scoreboard-driven
// line decoder per instance plus directed waveform and timing checks.
module tb_uart_tx_simple;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] serial_tx;
    logic [2:0] tx_done;
    logic [7:0] tx_byte [3];

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   done_cnt  [3];
    int   done_gap  [3];
    logic rx_par    [3];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            localparam int P       = (gi == 0) ? 0 : ((gi == 1) ? 1 : 2);
            localparam int S       = (gi == 2) ? 2 : 1;
            localparam int NB      = 1 + 8 + ((P != 0) ? 1 : 0) + S;
            localparam int F       = NB * CPB;
            localparam int PAR_IDX = (P != 0) ? 9 : -1;

            logic [7:0] exp_q [$];
            logic [7:0] exp_b;
            logic [7:0] rx_data;
            logic       rx_busy;
            logic       rx_prev;
            int         rx_t;
            int         bidx;
            int         hs_edge;
            int         last_done;

            uart_tx_simple #(
                .BAUD_RATE  (100000),
                .PARITY     (P),
                .STOP       (S),
                .CLK_FREQ_HZ(1000000)
            ) dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .tx_byte  (tx_byte[gi]),
                .tx_valid (tx_valid[gi]),
                .tx_ready (tx_ready[gi]),
                .serial_tx(serial_tx[gi]),
                .tx_done  (tx_done[gi])
            );

            // Scoreboard push on handshake, mid-bit decode of the line, pop at frame end.
            initial begin
                rx_busy   = 1'b0;
                rx_prev   = 1'b1;
                rx_t      = 0;
                rx_data   = '0;
                hs_edge   = 0;
                last_done = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        rx_busy = 1'b0;
                        rx_prev = 1'b1;
                        exp_q.delete();
                    end else begin
                        if (tx_done[gi]) begin
                            done_cnt[gi]++;
                            check($sformatf("ch%0d_done_time", gi), cyc, hs_edge + F);
                            done_gap[gi] = cyc - last_done;
                            last_done    = cyc;
                        end
                        if (tx_valid[gi] && tx_ready[gi]) begin
                            hs_edge = cyc + 1;
                            exp_q.push_back(tx_byte[gi]);
                        end
                        if (!rx_busy) begin
                            if (rx_prev && !serial_tx[gi]) begin
                                rx_busy = 1'b1;
                                rx_t    = 0;
                            end
                        end else begin
                            rx_t++;
                            if (rx_t % CPB == CPB / 2) begin
                                bidx = rx_t / CPB;
                                if (bidx == 0)
                                    check($sformatf("ch%0d_start_bit", gi), serial_tx[gi], 1'b0);
                                else if (bidx <= 8)
                                    rx_data[bidx-1] = serial_tx[gi];
                                else if (bidx == PAR_IDX)
                                    rx_par[gi] = serial_tx[gi];
                                else
                                    check($sformatf("ch%0d_stop_bit", gi), serial_tx[gi], 1'b1);
                                if (bidx == NB - 1) begin
                                    rx_busy = 1'b0;
                                    check($sformatf("ch%0d_frame_expected", gi), exp_q.size() != 0, 1'b1);
                                    if (exp_q.size() != 0) begin
                                        exp_b = exp_q.pop_front();
                                        check($sformatf("ch%0d_data", gi), rx_data, exp_b);
                                        if (P != 0)
                                            check($sformatf("ch%0d_parity", gi), rx_par[gi],
                                                  (P == 1) ? ~^exp_b : ^exp_b);
                                    end
                                end
                            end
                        end
                        rx_prev = serial_tx[gi];
                    end
                end
            end
        end
    endgenerate

    task automatic send(input int ch, input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1;
        while (tx_ready[ch] !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("ch%0d_ready_before_send", ch), tx_ready[ch], 1'b1);
        tx_byte[ch]  = b;
        tx_valid[ch] = 1'b1;
        @(posedge clk); #1;
        tx_valid[ch] = 1'b0;
    endtask

    task automatic wait_done(input int ch, input int target);
        int n = 0;
        while (done_cnt[ch] < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ch%0d_done_seen", ch), done_cnt[ch] >= target, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] frame;
        logic       exp_line;

        rst_n    = 1'b0;
        tx_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tx_byte[i]  = '0;
            done_cnt[i] = 0;
            done_gap[i] = 0;
            rx_par[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial_tx", serial_tx, 3'b111);
        check("rst_tx_ready", tx_ready, 3'b111);
        check("rst_tx_done", tx_done, 3'b000);
        rst_n = 1'b1;

        // 8N1 0xA5: exact line waveform, ready low for 100 clocks, done at +100
        send(0, 8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j <= 100; j++) begin
            @(negedge clk);
            exp_line = (j < 100) ? frame[j/10] : 1'b1;
            check($sformatf("t1_line_%0d", j), serial_tx[0], exp_line);
            check($sformatf("t1_ready_%0d", j), tx_ready[0], j == 100);
            check($sformatf("t1_done_%0d", j), tx_done[0], j == 100);
        end

        // 8O1 0x07: parity bit 0
        send(1, 8'h07);
        wait_done(1, 1);
        check("t2_parity_bit", rx_par[1], 1'b0);

        // 8E2 0x07: parity bit 1, 20 clocks of stop, done at +120
        send(2, 8'h07);
        for (int j = 0; j <= 120; j++) begin
            @(negedge clk);
            if (j >= 80) begin
                exp_line = (j < 90) ? 1'b0 : 1'b1;
                check($sformatf("t3_line_%0d", j), serial_tx[2], exp_line);
                check($sformatf("t3_ready_%0d", j), tx_ready[2], j == 120);
                check($sformatf("t3_done_%0d", j), tx_done[2], j == 120);
            end
        end
        wait_done(2, 1);
        check("t3_parity_bit", rx_par[2], 1'b1);

        // Back-to-back 0x00 then 0xFF with valid held high
        @(posedge clk); #1;
        check("t4_ready_idle", tx_ready[0], 1'b1);
        tx_byte[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        @(posedge clk); #1;
        tx_byte[0] = 8'hFF;
        repeat (101) @(negedge clk);
        check("t4_gap_line", serial_tx[0], 1'b1);
        check("t4_gap_done", tx_done[0], 1'b1);
        check("t4_gap_ready", tx_ready[0], 1'b1);
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        @(negedge clk);
        check("t4_second_start", serial_tx[0], 1'b0);
        check("t4_second_ready", tx_ready[0], 1'b0);
        wait_done(0, 3);
        check("t4_done_spacing", done_gap[0], 101);

        // tx_byte change after handshake and valid pulse mid-frame
        @(posedge clk); #1;
        tx_byte[0]  = 8'hC3;
        tx_valid[0] = 1'b1;
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        tx_byte[0]  = 8'h3C;
        repeat (40) @(posedge clk);
        #1 tx_valid[0] = 1'b1;
        @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        wait_done(0, 4);
        repeat (30) @(negedge clk);
        check("t5_no_second_frame_line", serial_tx[0], 1'b1);
        check("t5_no_second_frame_ready", tx_ready[0], 1'b1);
        check("t5_single_done", done_cnt[0], 4);

        // Asynchronous reset during data bit 4 of 0x00
        send(0, 8'h00);
        repeat (54) @(posedge clk);
        #1;
        check("t6_pre_reset_line", serial_tx[0], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_reset_line", serial_tx[0], 1'b1);
        check("t6_reset_ready", tx_ready[0], 1'b1);
        check("t6_reset_done", tx_done[0], 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 8'h5A);
        wait_done(0, 5);
        repeat (20) @(negedge clk);
        check("t6_done_count", done_cnt[0], 5);

        check("final_queue_ch0", g_ch[0].exp_q.size(), 0);
        check("final_queue_ch1", g_ch[1].exp_q.size(), 0);
        check("final_queue_ch2", g_ch[2].exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
